// File: rtl/cell_tile_renderer.sv
// cell_tile_renderer: fetches one board cell's state from BRAM and draws it as a
// filled CELL_W x CELL_W square on the VGA plot interface, then pulses cell_done.
module cell_tile_renderer #(
    parameter int CELL_W   = 10,
    parameter int GAP      = 2,
    parameter int RD_LAT   = 2,
    parameter int DATA_W   = 8,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cell_valid,
    input  logic [7:0]          cell_addr,
    output logic                cell_ready,
    output logic [7:0]          mem_addr,
    output logic                mem_rden,
    input  logic [DATA_W-1:0]   mem_q,
    output logic                plot,
    output logic [8:0]          vga_x,
    output logic [7:0]          vga_y,
    output logic [COLOUR_W-1:0] colour,
    output logic                cell_done,
    output logic                busy
);
    localparam int PITCH = CELL_W + GAP;
    localparam int CNT_W = $clog2(CELL_W);
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(CELL_W - 1);
    localparam logic [LAT_W-1:0] LAST_W = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_DRAW,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [8:0]            r_ox;
    logic [7:0]            r_oy;
    logic [CNT_W-1:0]      r_dx;
    logic [CNT_W-1:0]      r_dy;
    logic [LAT_W-1:0]      r_wait;
    logic [7:0]            r_mem_addr;
    logic                  r_mem_rden;
    logic                  r_plot;
    logic [8:0]            r_vga_x;
    logic [7:0]            r_vga_y;
    logic [COLOUR_W-1:0]   r_colour;
    logic                  r_cell_done;
    logic                  r_busy;
    logic                  r_ready;

    logic [3:0]            w_col;
    logic [3:0]            w_row;
    logic [8:0]            w_ox;
    logic [7:0]            w_oy;

    // Square origin: pitch * column/row; max 12*15 = 180 fits both widths.
    assign w_col = cell_addr[3:0];
    assign w_row = cell_addr[7:4];
    assign w_ox  = 9'(PITCH) * {5'd0, w_col};
    assign w_oy  = 8'(PITCH) * {4'd0, w_row};

    // NOTE: all state here is sequential, so every assignment in this block is
    // non-blocking; reset is synchronous and overrides every state transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ox        <= '0;
            r_oy        <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_wait      <= '0;
            r_mem_addr  <= '0;
            r_mem_rden  <= 1'b0;
            r_plot      <= 1'b0;
            r_vga_x     <= '0;
            r_vga_y     <= '0;
            r_colour    <= '0;
            r_cell_done <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_mem_rden  <= 1'b0;
            r_cell_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cell_valid) begin
                        r_mem_addr <= cell_addr;
                        r_ox       <= w_ox;
                        r_oy       <= w_oy;
                        r_mem_rden <= 1'b1;
                        r_busy     <= 1'b1;
                        r_ready    <= 1'b0;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data is valid only on the last wait cycle.
                    if (r_wait == LAST_W) begin
                        r_colour <= mem_q[COLOUR_W-1:0];
                        r_plot   <= 1'b1;
                        r_vga_x  <= r_ox;
                        r_vga_y  <= r_oy;
                        r_dx     <= '0;
                        r_dy     <= '0;
                        r_state  <= S_DRAW;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DRAW: begin
                    if (r_dx == LAST_D) begin
                        r_dx    <= '0;
                        r_vga_x <= r_ox;
                        if (r_dy == LAST_D) begin
                            r_plot      <= 1'b0;
                            r_cell_done <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_dy    <= r_dy + 1'b1;
                            r_vga_y <= r_vga_y + 8'd1;
                        end
                    end else begin
                        r_dx    <= r_dx + 1'b1;
                        r_vga_x <= r_vga_x + 9'd1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cell_ready = r_ready;
    assign mem_addr   = r_mem_addr;
    assign mem_rden   = r_mem_rden;
    assign plot       = r_plot;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign colour     = r_colour;
    assign cell_done  = r_cell_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_cell_tile_renderer.sv
// Self-checking bench for cell_tile_renderer: BRAM model, address-counter model,
// per-cell cycle-level reference and a full-board pixel coverage map.
module tb_cell_tile_renderer;
    localparam int CELL_W = 10;
    localparam int GAP    = 2;
    localparam int PITCH  = CELL_W + GAP;
    localparam int L      = 2;
    localparam int GRID   = 16 * PITCH;

    logic       clock;
    logic       reset;
    logic       cell_valid;
    logic [7:0] cell_addr;
    logic       cell_ready;
    logic [7:0] mem_addr;
    logic       mem_rden;
    logic [7:0] mem_q;
    logic       plot;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] colour;
    logic       cell_done;
    logic       busy;

    logic       tb_valid;
    logic [7:0] tb_addr;
    logic       sweep_en;
    logic [8:0] sweep_cnt;
    int         done_all;

    logic [7:0] mem [256];
    logic [7:0] q_pipe [L];
    logic       q_vld [L];
    logic [7:0] junk;

    int n_tests;
    int n_fail;
    int hits [GRID][GRID];
    int plot_cnt, done_cnt, oob, col_bad;

    cell_tile_renderer #(
        .CELL_W(CELL_W), .GAP(GAP), .RD_LAT(L), .DATA_W(8), .COLOUR_W(3)
    ) dut (
        .clock(clock), .reset(reset), .cell_valid(cell_valid), .cell_addr(cell_addr),
        .cell_ready(cell_ready), .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_q(mem_q),
        .plot(plot), .vga_x(vga_x), .vga_y(vga_y), .colour(colour),
        .cell_done(cell_done), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Address counter model: offers cells in order, advances on cell_done.
    assign cell_valid = sweep_en ? ~sweep_cnt[8] : tb_valid;
    assign cell_addr  = sweep_en ? sweep_cnt[7:0] : tb_addr;

    always @(posedge clock) begin
        if (!sweep_en) begin
            sweep_cnt <= '0;
        end else if (cell_done) begin
            if (sweep_cnt == 9'd255) done_all <= done_all + 1;
            sweep_cnt <= sweep_cnt + 9'd1;
        end
    end

    // BRAM model: data valid exactly L cycles after rden; random junk otherwise.
    always @(posedge clock) begin
        q_pipe[0] <= mem[mem_addr];
        q_vld[0]  <= mem_rden;
        for (int i = 1; i < L; i++) begin
            q_pipe[i] <= q_pipe[i-1];
            q_vld[i]  <= q_vld[i-1];
        end
        junk <= 8'($urandom);
    end
    assign mem_q = q_vld[L-1] ? q_pipe[L-1] : junk;

    // Sweep monitor: pixel coverage, colour per owning cell, pulse counts.
    always @(negedge clock) begin
        if (sweep_en) begin
            if (plot === 1'b1) begin
                plot_cnt++;
                if (int'(vga_x) < GRID && int'(vga_y) < GRID) begin
                    hits[vga_y][vga_x]++;
                    if (colour !== mem[(int'(vga_y) / PITCH) * 16 + int'(vga_x) / PITCH][2:0])
                        col_bad++;
                end else begin
                    oob++;
                end
            end
            if (cell_done === 1'b1) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one cell and compare every cycle up to the following IDLE cycle.
    task automatic run_cell(input logic [7:0] addr, input bit hold);
        int ox, oy, i;
        int b_rd, b_addr, b_plot, b_pix, b_done, b_stat;
        bit e_plot, e_busy;
        logic [2:0] c;
        ox = PITCH * int'(addr % 16);
        oy = PITCH * int'(addr / 16);
        c  = mem[addr][2:0];
        b_rd = 0; b_addr = 0; b_plot = 0; b_pix = 0; b_done = 0; b_stat = 0;
        @(negedge clock);
        tb_addr  = addr;
        tb_valid = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) tb_valid = 1'b0;
        for (int k = 1; k <= 103 + L; k++) begin
            @(negedge clock);
            if (hold && k == 50) tb_addr = addr ^ 8'($urandom_range(1, 255));
            e_plot = (k >= 2 + L) && (k <= 101 + L);
            e_busy = (k <= 102 + L);
            if (mem_rden !== (k == 1)) b_rd++;
            if (k <= 1 + L && mem_addr !== addr) b_addr++;
            if (plot !== e_plot) b_plot++;
            if (e_plot) begin
                i = k - 2 - L;
                if (vga_x !== 9'(ox + i % CELL_W) || vga_y !== 8'(oy + i / CELL_W) || colour !== c)
                    b_pix++;
            end
            if (cell_done !== (k == 102 + L)) b_done++;
            if (busy !== e_busy || cell_ready !== !e_busy) b_stat++;
        end
        tb_valid = 1'b0;
        check($sformatf("rden_a%0d", addr), b_rd, 0);
        check($sformatf("memaddr_a%0d", addr), b_addr, 0);
        check($sformatf("plot_a%0d", addr), b_plot, 0);
        check($sformatf("pixel_a%0d", addr), b_pix, 0);
        check($sformatf("done_a%0d", addr), b_done, 0);
        check($sformatf("status_a%0d", addr), b_stat, 0);
    endtask

    initial begin
        int n, bad, cyc;
        n_tests = 0; n_fail = 0;
        plot_cnt = 0; done_cnt = 0; oob = 0; col_bad = 0;
        done_all = 0;
        sweep_en = 1'b0;
        tb_valid = 1'b0;
        tb_addr  = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0]   = 8'h05;
        mem[17]  = 8'h02;
        mem[200] = 8'h08;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", cell_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_plot", plot, 0);
        check("rst_done", cell_done, 0);
        check("rst_rden", mem_rden, 0);
        check("rst_outs", {mem_addr, vga_x, vga_y, colour}, 0);
        n = 0;
        repeat (5) begin
            @(negedge clock);
            if (plot !== 1'b0 || cell_done !== 1'b0) n++;
        end
        check("idle_quiet", n, 0);

        run_cell(8'd0, 1'b0);
        run_cell(8'd17, 1'b0);
        run_cell(8'd255, 1'b0);
        run_cell(8'd200, 1'b0);
        run_cell(8'd90, 1'b1);
        for (int r = 0; r < 6; r++) run_cell(8'($urandom), 1'($urandom));

        // Reset on the 50th DRAW cycle abandons the square.
        @(negedge clock);
        tb_addr  = 8'd37;
        tb_valid = 1'b1;
        @(posedge clock);
        #1;
        tb_valid = 1'b0;
        n = 0; cyc = 0;
        while (n < 50 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (plot === 1'b1) n++;
        end
        check("mid_reach50", n, 50);
        reset = 1'b1;
        @(negedge clock);
        check("mid_plot", plot, 0);
        check("mid_ready", cell_ready, 1);
        check("mid_busy", busy, 0);
        reset = 1'b0;
        n = 0;
        repeat (120) begin
            @(negedge clock);
            if (plot !== 1'b0 || cell_done !== 1'b0) n++;
        end
        check("mid_no_done", n, 0);
        run_cell(8'd37, 1'b0);

        // Full sweep driven by the counter model.
        @(posedge clock);
        #1;
        sweep_en = 1'b1;
        cyc = 0;
        while (sweep_cnt !== 9'd256 && cyc < 256 * (103 + L) + 200) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("sweep_finished", sweep_cnt, 256);
        repeat (3) @(posedge clock);
        #1;
        check("sweep_plots", plot_cnt, 25600);
        check("sweep_dones", done_cnt, 256);
        check("sweep_done_all", done_all, 1);
        check("sweep_oob", oob, 0);
        check("sweep_colour", col_bad, 0);
        sweep_en = 1'b0;
        bad = 0;
        for (int y = 0; y < GRID; y++)
            for (int x = 0; x < GRID; x++)
                if (hits[y][x] != (((x % PITCH) < CELL_W && (y % PITCH) < CELL_W) ? 1 : 0))
                    bad++;
        check("sweep_coverage", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
